// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding, count width and default game parameters
package game_pkg;

  localparam int COUNT_W        = 5;
  localparam int DEF_ROUNDS     = 10;
  localparam int DEF_GAP_CYCLES = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_GEN   = 3'd2,
    ST_SHOW  = 3'd3,
    ST_INPUT = 3'd4,
    ST_SCORE = 3'd5,
    ST_GAP   = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter with enable and zero flag
module cycle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk_1,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/round_controller.sv
// rtl/round_controller.sv - game round sequencer; ROUND_TIMEOUT_EN adds an input-window timeout
module round_controller
  import game_pkg::*;
#(
  parameter int ROUNDS         = DEF_ROUNDS,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int LRST_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk_1,
  input  logic               rst,
  input  logic               start,
  input  logic               level_valid,
  input  logic               gen_done,
  input  logic               print_done,
  input  logic               input_done,
  input  logic               round_win,
  output logic               sub_rst_n,
  output logic               gen_en,
  output logic               print_en,
  output logic               input_en,
  output logic [COUNT_W-1:0] round_count,
  output logic [COUNT_W-1:0] answer_count,
  output logic               game_over,
  output logic               round_timeout
);

  localparam logic [3:0] LRST_LOAD = 4'(LRST_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES - 1);

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] round_q, round_d;
  logic [COUNT_W-1:0] answer_q, answer_d;
  logic               win_q, win_d;
  logic               ph_load, ph_en, ph_zero;
  logic [3:0]         ph_load_value;
  logic               timeout_expired;

  // One timer paces both the CLR hold and the GAP idle; it is loaded on entry.
  cycle_timer #(.WIDTH(4)) u_phase_timer (
    .clk_1      (clk_1),
    .rst        (rst),
    .load       (ph_load),
    .en         (ph_en),
    .load_value (ph_load_value),
    .zero       (ph_zero)
  );

`ifdef ROUND_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES) > 10) ? $clog2(TIMEOUT_CYCLES) : 10;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
  logic to_zero;

  cycle_timer #(.WIDTH(TO_W)) u_timeout_timer (
    .clk_1      (clk_1),
    .rst        (rst),
    .load       ((state_q == ST_SHOW) && print_done),
    .en         (state_q == ST_INPUT),
    .load_value (TO_LOAD),
    .zero       (to_zero)
  );

  assign timeout_expired = (state_q == ST_INPUT) && to_zero;
  assign round_timeout   = timeout_expired && !input_done;
`else
  assign timeout_expired = 1'b0;
  assign round_timeout   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    answer_d = answer_q;
    win_d    = win_q;
    case (state_q)
      ST_IDLE: begin
        if (start && level_valid) begin
          round_d  = '0;
          answer_d = '0;
          state_d  = ST_CLR;
        end
      end
      ST_CLR:   if (ph_zero)    state_d = ST_GEN;
      ST_GEN:   if (gen_done)   state_d = ST_SHOW;
      ST_SHOW:  if (print_done) state_d = ST_INPUT;
      ST_INPUT: begin
        // input_done wins over a timeout landing in the same cycle
        if (input_done) begin
          win_d   = round_win;
          state_d = ST_SCORE;
        end else if (timeout_expired) begin
          win_d   = 1'b0;
          state_d = ST_SCORE;
        end
      end
      ST_SCORE: begin
        round_d  = round_q + 1'b1;
        answer_d = answer_q + COUNT_W'(win_q);
        state_d  = (round_d == COUNT_W'(ROUNDS)) ? ST_DONE : ST_GAP;
      end
      ST_GAP:   if (ph_zero) state_d = ST_CLR;
      ST_DONE: begin
        if (start) begin
          round_d  = '0;
          answer_d = '0;
          state_d  = ST_CLR;
        end
      end
      default:  state_d = ST_IDLE;
    endcase

    ph_load       = ((state_d == ST_CLR) || (state_d == ST_GAP)) && (state_d != state_q);
    ph_load_value = (state_d == ST_GAP) ? GAP_LOAD : LRST_LOAD;
    ph_en         = (state_q == ST_CLR) || (state_q == ST_GAP);
  end

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      round_q  <= '0;
      answer_q <= '0;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      answer_q <= answer_d;
      win_q    <= win_d;
    end
  end

  // The loop reset is also held low while the controller itself is in reset.
  assign sub_rst_n    = rst && (state_q != ST_CLR);
  assign gen_en       = (state_q == ST_GEN);
  assign print_en     = (state_q == ST_SHOW);
  assign input_en     = (state_q == ST_INPUT);
  assign game_over    = (state_q == ST_DONE);
  assign round_count  = round_q;
  assign answer_count = answer_q;

endmodule
